// File: rtl/alu_issue.sv
// alu_issue: registered issue/capture front-end for the combinational alu.
// Accepts one request per transaction (IDLE -> EXEC -> RESP), drives the
// registered opcode/operands to the alu, captures alu_f one cycle later and
// holds the result until the consumer takes it.
// Optional feature: define ALU_ISSUE_DZ_GUARD_EN to substitute an all-ones
// result and raise out_dz on a divide by zero.
module alu_issue #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_oc,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [2:0]            alu_oc,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_f,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_f,
    output logic                  out_zero,
    output logic                  out_dz,
    output logic [7:0]            op_count
);

    localparam logic [2:0] OC_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // Ready depends on state only, so there is no path from out_ready.
    assign in_ready = (state == IDLE);

`ifdef ALU_ISSUE_DZ_GUARD_EN
    logic dz_hit;
    assign dz_hit = (alu_oc == OC_DIV) && (alu_b == '0);

    // Divide-by-zero flag, updated only when a result is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dz <= 1'b0;
        end else if (state == EXEC) begin
            out_dz <= dz_hit;
        end
    end
`else
    logic dz_hit;
    assign dz_hit = 1'b0;
    assign out_dz = 1'b0;
`endif

    // Transaction FSM: issue registers, result capture and completion count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_oc    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            out_f     <= '0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_oc <= in_oc;
                        alu_a  <= in_a;
                        alu_b  <= in_b;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // A guarded divide by zero never looks at alu_f.
                    if (dz_hit) begin
                        out_f    <= '1;
                        out_zero <= 1'b0;
                    end else begin
                        out_f    <= alu_f;
                        out_zero <= (alu_f == '0);
                    end
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases, backpressure, reset in
// flight, randomized transactions against a reference model, op_count wrap.
module tb_alu_issue;

    localparam int DW = 16;
    localparam logic [DW-1:0] DZ_STUB = 16'hDEAD;  // what the stub alu gives on /0

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_oc;
    logic [DW-1:0] in_a, in_b;
    logic [2:0]    alu_oc;
    logic [DW-1:0] alu_a, alu_b, alu_f;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_f;
    logic          out_zero, out_dz;
    logic [7:0]    op_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    alu_issue #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_oc(in_oc), .in_a(in_a), .in_b(in_b),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_zero(out_zero), .out_dz(out_dz),
        .op_count(op_count)
    );

    // Stand-in for the combinational alu.
    always_comb begin
        alu_f = '0;
        case (alu_oc)
            3'd0: alu_f = alu_a + alu_b;
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = alu_a * alu_b;
            3'd3: alu_f = (alu_b == '0) ? DZ_STUB : alu_a / alu_b;
            3'd4: alu_f = ~alu_a;
            3'd5: alu_f = alu_a ^ alu_b;
            3'd6: alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the consumer should see for a request.
    task automatic ref_model(input logic [2:0] oc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             output logic [DW-1:0] f, output logic dz);
        int unsigned ua, ub, r;
        ua = a; ub = b; dz = 1'b0;
        case (oc)
            3'd0: r = ua + ub;
            3'd1: r = ua - ub;
            3'd2: r = ua * ub;
            3'd3: begin
                if (ub == 0) begin
`ifdef ALU_ISSUE_DZ_GUARD_EN
                    r = 32'hFFFF_FFFF; dz = 1'b1;
`else
                    r = DZ_STUB;
`endif
                end else r = ua / ub;
            end
            3'd4: r = ~ua;
            3'd5: r = ua ^ ub;
            3'd6: r = ua | ub;
            default: r = ua & ub;
        endcase
        f = r[DW-1:0];
    endtask

    // One complete transaction starting and ending at a negedge in IDLE.
    task automatic txn(input logic [2:0] oc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int rdy_delay, input bit full);
        logic [DW-1:0] ef;
        logic edz;
        ref_model(oc, a, b, ef, edz);
        if (full) check("idle_in_ready", in_ready, 1);
        in_valid = 1; in_oc = oc; in_a = a; in_b = b; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0; in_a = DW'($urandom); in_b = DW'($urandom);
        @(negedge clk);
        if (full) begin
            check("exec_in_ready", in_ready, 0);
            check("exec_out_valid", out_valid, 0);
            check("alu_oc", alu_oc, oc);
            check("alu_a", alu_a, a);
            check("alu_b", alu_b, b);
        end
        @(negedge clk);
        check("out_valid", out_valid, 1);
        check("out_f", out_f, ef);
        check("out_zero", out_zero, (ef == '0));
        check("out_dz", out_dz, edz);
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            if (full) begin
                check("hold_valid", out_valid, 1);
                check("hold_f", out_f, ef);
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        exp_count = (exp_count + 1) % 256;
        @(negedge clk);
        check("done_valid", out_valid, 0);
        check("op_count", op_count, exp_count);
    endtask

    initial begin
        logic [2:0] roc;
        logic [DW-1:0] ra, rb;
        rst_n = 0; in_valid = 0; in_oc = 0; in_a = 0; in_b = 0; out_ready = 0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_out_f", out_f, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_dz", out_dz, 0);
        check("rst_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Directed cases
        txn(3'd0, 16'd5, 16'd3, 0, 1);
        txn(3'd1, 16'h1234, 16'h1234, 1, 1);
        txn(3'd2, 16'h0100, 16'h0100, 0, 1);
        txn(3'd3, 16'd7, 16'd0, 0, 1);
        txn(3'd3, 16'd9, 16'd2, 2, 1);
        txn(3'd4, 16'h00FF, 16'h0000, 0, 1);

        // Backpressure with in_valid held high and operands changing
        in_valid = 1; in_oc = 3'd0; in_a = 16'h0011; in_b = 16'h0022; out_ready = 0;
        @(posedge clk); #1;
        in_oc = 3'd5; in_a = 16'h0033; in_b = 16'h0044;
        @(negedge clk);
        @(negedge clk);
        check("bp_out_f", out_f, 16'h0033);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_oc = 3'(i); in_a = DW'($urandom); in_b = DW'($urandom);
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_f", out_f, 16'h0033);
            check("bp_alu_oc", alu_oc, 3'd0);
            check("bp_alu_a", alu_a, 16'h0011);
            check("bp_alu_b", alu_b, 16'h0022);
        end
        in_oc = 3'd6; in_a = 16'h0055; in_b = 16'h0066;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        exp_count = (exp_count + 1) % 256;
        @(negedge clk);
        check("bp_count", op_count, exp_count);
        check("bp_ready_back", in_ready, 1);
        check("bp_not_taken", alu_a, 16'h0011);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        check("bp2_alu_oc", alu_oc, 3'd6);
        check("bp2_alu_a", alu_a, 16'h0055);
        @(negedge clk);
        check("bp2_out_f", out_f, 16'h0077);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        exp_count = (exp_count + 1) % 256;
        @(negedge clk);
        check("bp2_count", op_count, exp_count);

        // Reset while in EXEC
        in_valid = 1; in_oc = 3'd0; in_a = 16'd1; in_b = 16'd2;
        @(posedge clk); #1;
        in_valid = 0;
        #1 rst_n = 0;
        #1;
        check("mr_in_ready", in_ready, 1);
        check("mr_valid", out_valid, 0);
        check("mr_alu_oc", alu_oc, 0);
        check("mr_alu_a", alu_a, 0);
        check("mr_alu_b", alu_b, 0);
        check("mr_count", op_count, 0);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("mr_idle_valid", out_valid, 0);
        txn(3'd0, 16'd5, 16'd3, 0, 1);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            roc = 3'($urandom_range(0, 7));
            ra = DW'($urandom);
            rb = (roc == 3'd3) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            txn(roc, ra, rb, $urandom_range(0, 3), 1);
        end

        // op_count wrap
        while (exp_count != 255) txn(3'($urandom_range(0, 7)), DW'($urandom), DW'($urandom_range(1, 9)), 0, 0);
        check("wrap_255", op_count, 8'd255);
        txn(3'd7, 16'hF0F0, 16'h0FF0, 0, 0);
        check("wrap_0", op_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential front-end that initiates operations on the combinational `alu` block. It accepts an operation request over a valid/ready handshake, registers opcode and operands onto the ALU input ports, and captures the ALU result one cycle later. It presents the result, with status flags, over a second valid/ready handshake. It sits between the control unit and `alu`, making ALU use a timed, back-pressurable transaction.

## Interface
- `DATA_WIDTH`, 16, operand/result width; must match the attached `alu`.
- `clk` input 1 — single clock; all state on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — request present.
- `in_ready` output 1 — block can accept a request.
- `in_oc` input 3 — opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not a, 101 xor, 110 or, 111 and.
- `in_a` input DATA_WIDTH — operand a.
- `in_b` input DATA_WIDTH — operand b.
- `alu_oc` output 3 — registered opcode to `alu`.
- `alu_a` output DATA_WIDTH — registered operand a to `alu`.
- `alu_b` output DATA_WIDTH — registered operand b to `alu`.
- `alu_f` input DATA_WIDTH — result from `alu`.
- `out_valid` output 1 — result present.
- `out_ready` input 1 — consumer takes result.
- `out_f` output DATA_WIDTH — captured result.
- `out_zero` output 1 — `out_f` is all zeros.
- `out_dz` output 1 — divide by zero (see Configuration).
- `op_count` output 8 — completed transactions, modulo 256.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready` at an edge, latch `in_oc`/`in_a`/`in_b` into `alu_oc`/`alu_a`/`alu_b`, then go to EXEC. With no request, stay in IDLE.
- EXEC: `in_ready`=0. At the next edge, capture the result into `out_f`, compute `out_zero` from the captured value, set `out_valid`=1, then go to RESP.
- RESP: `in_ready`=0. `out_f`, the flags and the `alu_*` outputs hold stable. On `out_valid`&&`out_ready` at an edge: clear `out_valid`, increment `op_count`, go to IDLE.
- `in_valid` outside IDLE is ignored. No request is queued.
- `alu_*` outputs hold their last values in IDLE. They change only on acceptance.
- Arithmetic is defined by `alu`. Results are truncated to DATA_WIDTH (mul gives the low half), with no carry or overflow flag. `out_zero` = (`out_f` == 0) after any substitution below.
- `op_count` wraps from 255 to 0. It does not saturate.
- Reset at any time forces IDLE immediately. Any in-flight transaction is discarded and not counted.
- Reset values: `alu_oc`=0, `alu_a`=0, `alu_b`=0, `out_f`=0, `out_valid`=0, `out_zero`=0, `out_dz`=0, `op_count`=0. `in_ready`=1, since it decodes IDLE combinationally.

## Timing
- Request accepted at edge N. `out_valid` rises after edge N+1, so latency is 1 cycle from acceptance to result valid.
- If `out_ready` is high during RESP, the handshake completes at edge N+2. `in_ready` rises after N+2, and the next acceptance is at the earliest edge N+3. Peak throughput is one operation per 3 cycles.
- `in_ready` is a function of state only, with no combinational path from `out_ready`.
- `alu_f` is sampled only at the EXEC→RESP edge. Consequently, `alu` settling must fit in one clock period.
- `out_ready` held low keeps RESP indefinitely, with all outputs frozen.

## Configuration
- `ALU_ISSUE_DZ_GUARD_EN` defined:
  - At the EXEC→RESP edge, if `alu_oc`==011 and `alu_b`==0, then `out_f` = all ones, `out_dz`=1 and `alu_f` is ignored.
  - `out_dz` is 0 for every other case.
- `ALU_ISSUE_DZ_GUARD_EN` undefined:
  - `out_f` = `alu_f` always.
  - `out_dz` is tied to 0.

## Test plan
- Add: request 000, a=5, b=3 → `out_valid` 2 edges after request; `out_f`=8, `out_zero`=0, `op_count`=1 after handshake.
- Zero flag: request 001, a=0x1234, b=0x1234 → `out_f`=0, `out_zero`=1. Request 010, a=0x0100, b=0x0100 → `out_f`=0 (truncation), `out_zero`=1.
- Backpressure: `out_ready` low for 5 cycles after `out_valid`; `in_valid` held high with new operands throughout → `out_f` and `alu_*` unchanged, `in_ready`=0. The second request is accepted only after the handshake, with `op_count`=1 before acceptance.
- Divide by zero: request 011, a=7, b=0 → with macro `out_f`=0xFFFF, `out_dz`=1, `out_zero`=0. Without macro, `out_dz`=0. Request 011, a=9, b=2 → `out_f`=4, `out_dz`=0.
- Reset: assert `rst_n`=0 mid-cycle while in EXEC → immediate IDLE, `out_valid`=0, `alu_*`=0, `op_count`=0. After release, a new add completes normally.
- Wrap: 256 back-to-back transactions → `op_count` reads 255 then 0.
